until_monitor: RTL and testbench

UNTIL_MONITOR -- requirements
Module: until_monitor

---
 rtl/until_monitor_pkg.sv | 7 +
 rtl/seq_rep_detect.sv | 17 +
 rtl/until_monitor.sv | 70 +++++++
 tb/tb_until_monitor.sv | 88 ++++++++
 4 files changed

// File: rtl/until_monitor_pkg.sv
// until_monitor_pkg: FSM states and sizing constants shared by the until monitor.
package until_monitor_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CHECK, DRAIN} state_t;
  localparam int MAX_C_DELAY = 8;
  localparam int MAX_REP = 15;
  localparam int CNT_W = 8;
endpackage

// File: rtl/seq_rep_detect.sv
// seq_rep_detect: flags the cycle that completes a run of REP consecutive D samples.
module seq_rep_detect import until_monitor_pkg::*; #(
  parameter int REP = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic D,
  output logic triggered
);
  localparam int RW = $clog2(MAX_REP + 1);
  localparam logic [RW-1:0] R = RW'(REP);
  logic [RW-1:0] run;
  always_ff @(posedge clock)
    if (reset) run <= '0;
    else run <= !D ? '0 : (run == R ? run : run + 1'b1);
  assign triggered = D && (run >= R - 1'b1);
endmodule

// File: rtl/until_monitor.sv
// until_monitor: checks $rose(A) |=> (B ##C_DELAY C) until[_with] D[*REP].triggered.
// Define UNTIL_MONITOR_COUNT_EN to build the saturating fail_count register.
module until_monitor import until_monitor_pkg::*; #(
  parameter int STRONG = 0,
  parameter int C_DELAY = 2,
  parameter int REP = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic active,
  output logic fail,
  output logic fail_sticky,
  output logic done,
  output logic overlap,
  output logic [CNT_W-1:0] fail_count
);
  state_t state, nxt;
  logic a_q, ov_q, triggered, rose, checking, sched, b_bad, c_bad, viol, done_nxt;
  logic [C_DELAY-1:0] sr, sr_nxt;
  seq_rep_detect #(.REP(REP)) u_rep (.clock(clock), .reset(reset), .D(D), .triggered(triggered));
  // ARMED is the first check cycle (rose+1); it always hands over to CHECK unless the obligation ends there
  always_comb begin
    rose = A && !a_q;
    checking = state == ARMED || state == CHECK;
    sched = checking && (!triggered || STRONG != 0);
    b_bad = sched && !B;
    c_bad = state != IDLE && sr[C_DELAY-1] && !C;
    viol = b_bad || c_bad;
    sr_nxt = viol ? '0 : (sr << 1) | C_DELAY'(sched);
    done_nxt = state == DRAIN && sr == '0;
    nxt = viol ? IDLE :
          state == IDLE ? (rose ? ARMED : IDLE) :
          checking ? (triggered ? DRAIN : CHECK) :
          sr == '0 ? (rose ? ARMED : IDLE) : DRAIN;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      a_q <= 1'b0;
      sr <= '0;
      ov_q <= 1'b0;
      active <= 1'b0;
      fail <= 1'b0;
      fail_sticky <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      a_q <= A;
      sr <= sr_nxt;
      ov_q <= overlap;
      active <= nxt != IDLE;
      fail <= viol;
      fail_sticky <= fail_sticky || viol;
      done <= done_nxt;
    end
  assign overlap = ov_q || (rose && state != IDLE);
`ifdef UNTIL_MONITOR_COUNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clock)
    if (reset) cnt <= '0;
    else if (viol && cnt != '1) cnt <= cnt + 1'b1;
  assign fail_count = cnt;
`else
  assign fail_count = '0;
`endif
endmodule

// File: tb/tb_until_monitor.sv
// tb_until_monitor: directed traces on a weak and a strong monitor, checked per cycle as 16-bit masks.
module tb_until_monitor;
  logic clock = 0, reset = 1, A = 0, B = 0, C = 0, D = 0;
  logic w_act, w_fail, w_sticky, w_done, w_ov, s_act, s_fail, s_sticky, s_done, s_ov;
  logic [7:0] w_cnt, s_cnt;
  logic [15:0] wf, wd, wa, wo, sf, sd, sa, so;
  int n_vec = 0, n_bad = 0;
`ifdef UNTIL_MONITOR_COUNT_EN
  localparam bit CE = 1;
`else
  localparam bit CE = 0;
`endif
  until_monitor #(.STRONG(0)) u_weak (.clock(clock), .reset(reset), .A(A), .B(B), .C(C), .D(D),
    .active(w_act), .fail(w_fail), .fail_sticky(w_sticky), .done(w_done), .overlap(w_ov), .fail_count(w_cnt));
  until_monitor #(.STRONG(1)) u_strong (.clock(clock), .reset(reset), .A(A), .B(B), .C(C), .D(D),
    .active(s_act), .fail(s_fail), .fail_sticky(s_sticky), .done(s_done), .overlap(s_ov), .fail_count(s_cnt));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // bit t of each mask is the value in cycle t; cycle 0 is the first cycle after reset
  task automatic run(input logic [15:0] a, b, c, d, r);
    reset = 1; A = 0; B = 0; C = 0; D = 0;
    @(posedge clock); #1;
    for (int t = 0; t < 16; t++) begin
      reset = r[t]; A = a[t]; B = b[t]; C = c[t]; D = d[t];
      #1;
      wf[t] = w_fail; wd[t] = w_done; wa[t] = w_act; wo[t] = w_ov;
      sf[t] = s_fail; sd[t] = s_done; sa[t] = s_act; so[t] = s_ov;
      @(posedge clock); #1;
    end
  endtask
  initial begin
    run(16'h0002, 16'h003C, 16'h00F0, 16'h0060, 16'h0000);
    chk("r38_w_fail", wf, 16'h0000);
    chk("r38_w_done", wd, 16'h0200);
    chk("r38_w_active", wa, 16'h01FC);
    chk("r38_w_count", {8'h00, w_cnt}, 16'h0000);
    chk("r40_s_fail", sf, 16'h0080);
    chk("r40_s_done", sd, 16'h0000);
    chk("r40_s_active", sa, 16'h007C);
    chk("r40_s_sticky", {15'h0, s_sticky}, 16'h0001);
    chk("r40_s_count", {8'h00, s_cnt}, CE ? 16'h0001 : 16'h0000);
    run(16'h0002, 16'h003C, 16'h00F0, 16'h0050, 16'h0000);
    chk("r39_w_fail", wf, 16'h0080);
    chk("r39_w_active", wa, 16'h007C);
    chk("r39_w_done", wd, 16'h0000);
    chk("r39_w_count", {8'h00, w_cnt}, CE ? 16'h0001 : 16'h0000);
    chk("r39_s_fail", sf, 16'h0080);
    run(16'h0002, 16'h007C, 16'h01F0, 16'h0060, 16'h0000);
    chk("r41_s_fail", sf, 16'h0000);
    chk("r41_s_done", sd, 16'h0400);
    chk("r41_s_active", sa, 16'h03FC);
    chk("r41_w_done", wd, 16'h0200);
    chk("r41_w_fail", wf, 16'h0000);
    run(16'h0002, 16'h003C, 16'h00F0, 16'h0050, 16'h0010);
    chk("r42_w_fail", wf, 16'h0000);
    chk("r42_w_done", wd, 16'h0000);
    chk("r42_w_active", wa, 16'h001C);
    chk("r42_s_fail", sf, 16'h0000);
    chk("r42_s_active", sa, 16'h001C);
    chk("r42_w_sticky", {15'h0, w_sticky}, 16'h0000);
    run(16'h000A, 16'h003C, 16'h00F0, 16'h0060, 16'h0000);
    chk("r43_w_overlap", wo, 16'hFFF8);
    chk("r43_w_done", wd, 16'h0200);
    chk("r43_w_fail", wf, 16'h0000);
    chk("r43_s_overlap", so, 16'hFFF8);
    reset = 1; A = 0; B = 0; C = 0; D = 0;
    @(posedge clock); #1;
    reset = 0;
    for (int i = 0; i < 300; i++) begin
      A = 1;
      @(posedge clock); #1;
      A = 0;
      repeat (3) @(posedge clock);
      #1;
    end
    chk("sat_w_count", {8'h00, w_cnt}, CE ? 16'h00FF : 16'h0000);
    chk("sat_s_count", {8'h00, s_cnt}, CE ? 16'h00FF : 16'h0000);
    chk("sat_w_sticky", {15'h0, w_sticky}, 16'h0001);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
